// File: rtl/byte_load_sequencer_pkg.sv
// Shared widths, state encoding and defaults for the byte load sequencer.
package byte_load_sequencer_pkg;

    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned CNT_W         = 3;
    localparam int unsigned EN_CNT_W      = 4;
    localparam int unsigned EN_CYCLES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ENABLE = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

endpackage

// File: rtl/byte_load_sequencer_serial_shift_reg.sv
// Serial-to-parallel shifter; next_c exposes the post-shift value so the
// caller can capture a completed byte on the same edge that accepts the last bit.
module serial_shift_reg
    import byte_load_sequencer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              restart,
    input  logic              shift_en,
    input  logic              bit_in,
    output logic [BYTE_W-1:0] next_c
);

    logic [BYTE_W-1:0] value;
    logic [BYTE_W-1:0] base_c;

    // A restart discards the partial byte before the incoming bit is shifted in.
    always_comb begin
        base_c = restart ? '0 : value;
        next_c = base_c;
        if (shift_en) begin
            if (MSB_FIRST) begin
                next_c = {base_c[BYTE_W-2:0], bit_in};
            end else begin
                next_c = {bit_in, base_c[BYTE_W-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else begin
            value <= next_c;
        end
    end

endmodule

// File: rtl/byte_load_sequencer.sv
// Assembles a serial byte and drives an external transparent latch with a
// setup / enable / hold sequence so data is stable whenever latch_en is high.
module byte_load_sequencer
    import byte_load_sequencer_pkg::*;
#(
    parameter int unsigned EN_CYCLES = EN_CYCLES_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              clear,
    output logic [BYTE_W-1:0] latch_d,
    output logic              latch_en,
    output logic              latch_clr,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [EN_CNT_W-1:0] en_cnt;
    logic                frame_open_c;
    logic                restart_c;
    logic                shift_en_c;
    logic [BYTE_W-1:0]   shift_next_c;

    // Bits are only accepted while a frame can be opened or is being collected.
    assign frame_open_c = (state == ST_IDLE) || (state == ST_SHIFT);
    assign restart_c    = !clear && start && frame_open_c;
    assign shift_en_c   = !clear && bit_valid && ((state == ST_SHIFT) || restart_c);

    serial_shift_reg #(
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clear),
        .restart  (restart_c),
        .shift_en (shift_en_c),
        .bit_in   (bit_in),
        .next_c   (shift_next_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            en_cnt    <= '0;
            latch_d   <= '0;
            latch_en  <= 1'b0;
            latch_clr <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            latch_clr <= 1'b0;
            done      <= 1'b0;
            if (clear) begin
                state     <= ST_IDLE;
                bit_cnt   <= '0;
                en_cnt    <= '0;
                latch_d   <= '0;
                latch_en  <= 1'b0;
                latch_clr <= 1'b1;
                busy      <= 1'b0;
                overrun   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state   <= ST_SHIFT;
                            busy    <= 1'b1;
                            bit_cnt <= CNT_W'(bit_valid);
                        end
                    end
                    ST_SHIFT: begin
                        if (start) begin
                            overrun <= 1'b1;
                            bit_cnt <= CNT_W'(bit_valid);
                        end else if (bit_valid) begin
                            if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                                state   <= ST_SETUP;
                                latch_d <= shift_next_c;
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ST_SETUP: begin
                        if (start || bit_valid) overrun <= 1'b1;
                        state    <= ST_ENABLE;
                        latch_en <= 1'b1;
                        en_cnt   <= '0;
                    end
                    ST_ENABLE: begin
                        if (start || bit_valid) overrun <= 1'b1;
                        en_cnt <= en_cnt + EN_CNT_W'(1);
                        // Drop enable and announce the commit on the same edge.
                        if (en_cnt == EN_CNT_W'(EN_CYCLES - 1)) begin
                            state    <= ST_HOLD;
                            latch_en <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        if (start || bit_valid) overrun <= 1'b1;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        busy     <= 1'b0;
                        latch_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_byte_load_sequencer.sv
// Scoreboard bench: two sequencers (MSB-first/EN=2, LSB-first/EN=3) share one
// randomized stimulus stream; expected commits are queued and checked on done.
module tb_byte_load_sequencer;

    localparam int EN0 = 2;
    localparam int EN1 = 3;

    typedef struct {
        logic [7:0] d;
        logic       ovr;
        int         t8;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] ld [2];
    logic       en [2];
    logic       clr [2];
    logic       bs [2];
    logic       dn [2];
    logic       ov [2];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic ovr_m = 1'b0;
    exp_t q0[$];
    exp_t q1[$];
    logic en_prev [2];
    int   en_run [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    byte_load_sequencer #(.EN_CYCLES(EN0), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset_n(reset_n), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .clear(clear), .latch_d(ld[0]), .latch_en(en[0]),
        .latch_clr(clr[0]), .busy(bs[0]), .done(dn[0]), .overrun(ov[0])
    );

    byte_load_sequencer #(.EN_CYCLES(EN1), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset_n(reset_n), .start(start), .bit_in(bit_in),
        .bit_valid(bit_valid), .clear(clear), .latch_d(ld[1]), .latch_en(en[1]),
        .latch_clr(clr[1]), .busy(bs[1]), .done(dn[1]), .overrun(ov[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int i);
        exp_t e;
        if (i == 0) e = q0[0];
        else        e = q1[0];
        return e;
    endfunction

    function automatic exp_t qpop(input int i);
        exp_t e;
        if (i == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        return e;
    endfunction

    // Monitor: checks enable window and commit against queued expectations.
    initial begin
        exp_t e;
        int   enc;
        en_prev = '{1'b0, 1'b0};
        en_run  = '{0, 0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                enc = (i == 0) ? EN0 : EN1;
                if (!reset_n) begin
                    en_prev[i] = 1'b0;
                    en_run[i]  = 0;
                end else begin
                    if (en[i] && !en_prev[i]) begin
                        if (qsize(i) == 0) begin
                            chk("en_unexpected", 32'(i + 1), 32'(0));
                        end else begin
                            e = qfront(i);
                            chk("en_start_cycle", cyc, e.t8 + 1);
                            chk("d_at_en_start", 32'(ld[i]), 32'(e.d));
                        end
                    end
                    if (en[i]) begin
                        en_run[i]++;
                    end else if (en_prev[i]) begin
                        if (!clr[i]) chk("en_length", en_run[i], enc);
                        en_run[i] = 0;
                    end
                    if (dn[i]) begin
                        if (qsize(i) == 0) begin
                            chk("done_unexpected", 32'(i + 1), 32'(0));
                        end else begin
                            e = qpop(i);
                            chk("done_cycle", cyc, e.t8 + 1 + enc);
                            chk("done_latch_d", 32'(ld[i]), 32'(e.d));
                            chk("done_overrun", 32'(ov[i]), 32'(e.ovr));
                            chk("done_busy", 32'(bs[i]), 32'(1));
                            chk("done_en_low", 32'(en[i]), 32'(0));
                        end
                    end
                    en_prev[i] = en[i];
                end
            end
        end
    end

    task automatic step(input logic s, input logic v, input logic b);
        start = s; bit_valid = v; bit_in = b;
        @(posedge clk); #1;
        start = 1'b0; bit_valid = 1'b0; bit_in = 1'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_en"}, 32'(en[i]), 32'(0));
            chk({tag, "_busy"}, 32'(bs[i]), 32'(0));
            chk({tag, "_clr"}, 32'(clr[i]), 32'(1));
            chk({tag, "_d"}, 32'(ld[i]), 32'(0));
            chk({tag, "_done"}, 32'(dn[i]), 32'(0));
            chk({tag, "_ovr"}, 32'(ov[i]), 32'(0));
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) chk("clr_held_after_release", 32'(clr[i]), 32'(1));
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) chk("clr_drops", 32'(clr[i]), 32'(0));
    endtask

    task automatic drop_reset_between_edges();
        #1;
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        ovr_m = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        release_reset();
    endtask

    task automatic do_clear(input logic with_start);
        start = with_start; clear = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        q0.delete(); q1.delete();
        ovr_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("clear_clr", 32'(clr[i]), 32'(1));
            chk("clear_d", 32'(ld[i]), 32'(0));
            chk("clear_ovr", 32'(ov[i]), 32'(0));
            chk("clear_busy", 32'(bs[i]), 32'(0));
            chk("clear_en", 32'(en[i]), 32'(0));
            chk("clear_done", 32'(dn[i]), 32'(0));
        end
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            chk("clear_clr_one_cycle", 32'(clr[i]), 32'(0));
            chk("clear_stays_idle", 32'(bs[i]), 32'(0));
        end
    endtask

    // abort: 0 none, 1 clear in first enable cycle, 2 reset in SHIFT, 3 reset in ENABLE
    task automatic frame(input logic [7:0] r, input int restart_k, input int abort,
                         input bit noise, input bit gaps);
        logic [7:0] rev;
        int         first;
        for (int i = 0; i < 8; i++) rev[i] = r[7-i];
        if (restart_k > 0) begin
            step(1'b1, 1'b0, 1'b0);
            for (int k = 0; k < restart_k; k++) step(1'b0, 1'b1, 1'($urandom));
            ovr_m = 1'b1;
        end
        if (gaps && ($urandom % 2 == 0)) begin
            step(1'b1, 1'b1, r[7]);
            first = 1;
        end else begin
            step(1'b1, 1'b0, 1'b0);
            first = 0;
        end
        for (int i = first; i < 8; i++) begin
            if (gaps) repeat ($urandom % 3) step(1'b0, 1'b0, 1'($urandom));
            if (abort == 2 && i == 4) begin
                chk("busy_before_rst", 32'(bs[0] & bs[1]), 32'(1));
                drop_reset_between_edges();
                return;
            end
            if (i == 7) begin
                if (noise) ovr_m = 1'b1;
                q0.push_back('{r, ovr_m, cyc + 1});
                q1.push_back('{rev, ovr_m, cyc + 1});
            end
            step(1'b0, 1'b1, r[7-i]);
        end
        if (noise) step(($urandom % 2) == 0, 1'b1, 1'($urandom));
        if (abort == 1 || abort == 3) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) chk("en_high_first", 32'(en[i]), 32'(1));
            if (abort == 3) begin
                drop_reset_between_edges();
                return;
            end
            clear = 1'b1;
            @(posedge clk); #1;
            clear = 1'b0;
            q0.delete(); q1.delete();
            ovr_m = 1'b0;
            for (int i = 0; i < 2; i++) begin
                chk("abort_en", 32'(en[i]), 32'(0));
                chk("abort_clr", 32'(clr[i]), 32'(1));
                chk("abort_busy", 32'(bs[i]), 32'(0));
                chk("abort_d", 32'(ld[i]), 32'(0));
            end
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) chk("abort_clr_one_cycle", 32'(clr[i]), 32'(0));
            return;
        end
        for (int k = 0; k < 40 && (bs[0] || bs[1]); k++) step(1'b0, 1'b0, 1'b0);
        chk("idle_timeout", 32'(bs[0] | bs[1]), 32'(0));
        chk("hold_d_msb", 32'(ld[0]), 32'(r));
        chk("hold_d_lsb", 32'(ld[1]), 32'(rev));
        for (int i = 0; i < 2; i++) chk("ovr_after_frame", 32'(ov[i]), 32'(ovr_m));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        release_reset();

        frame(8'hA5, 0, 0, 1'b0, 1'b0);
        frame(8'hA5, 0, 0, 1'b0, 1'b1);
        frame(8'h3C, 4, 0, 1'b0, 1'b1);
        do_clear(1'b0);
        frame(8'h5A, 0, 1, 1'b0, 1'b0);
        frame(8'h96, 0, 2, 1'b0, 1'b1);
        frame(8'hC3, 0, 3, 1'b0, 1'b0);
        frame(8'hFF, 0, 0, 1'b0, 1'b1);
        frame(8'h81, 0, 0, 1'b1, 1'b0);
        do_clear(1'b1);

        for (int n = 0; n < 30; n++) begin
            frame(8'($urandom), ($urandom % 4 == 0) ? 1 + int'($urandom % 7) : 0, 0,
                  ($urandom % 5) == 0, 1'b1);
            repeat ($urandom % 3) step(1'b0, 1'b1, 1'($urandom));
            for (int i = 0; i < 2; i++) begin
                chk("idle_noise_busy", 32'(bs[i]), 32'(0));
                chk("idle_noise_ovr", 32'(ov[i]), 32'(ovr_m));
            end
            if ($urandom % 6 == 0) do_clear(1'($urandom));
        end

        repeat (4) step(1'b0, 1'b0, 1'b0);
        chk("queues_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
